// File: rtl/jk_ff_bank.sv
// Bank of WIDTH flip-flop cells with run-time JK/D/T/SR mode, parallel load,
// change detection, a sticky SR-illegal flag and a saturating change counter.
module jk_ff_bank #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter int               CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             err_clr,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             changed,
    output logic             sr_err,
    output logic [CNT_W-1:0] chg_cnt
);

    localparam logic [1:0] MODE_JK = 2'b00;
    localparam logic [1:0] MODE_D  = 2'b01;
    localparam logic [1:0] MODE_T  = 2'b10;
    localparam logic [1:0] MODE_SR = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] q_next;
    logic             sr_illegal;
    logic             change;

    always_comb begin
        q_next     = q;
        sr_illegal = 1'b0;
        if (load) begin
            q_next = load_data;
        end else if (en) begin
            case (mode)
                MODE_JK: begin
                    for (int i = 0; i < WIDTH; i++) begin
                        case ({j[i], k[i]})
                            2'b01:   q_next[i] = 1'b0;
                            2'b10:   q_next[i] = 1'b1;
                            2'b11:   q_next[i] = ~q[i];
                            default: q_next[i] = q[i];
                        endcase
                    end
                end
                MODE_D: q_next = j;
                MODE_T: q_next = q ^ j;
                MODE_SR: begin
                    // An illegal S=R=1 bit holds; the remaining bits still update.
                    for (int i = 0; i < WIDTH; i++) begin
                        case ({j[i], k[i]})
                            2'b01:   q_next[i] = 1'b0;
                            2'b10:   q_next[i] = 1'b1;
                            default: q_next[i] = q[i];
                        endcase
                    end
                    sr_illegal = |(j & k);
                end
                default: q_next = q;
            endcase
        end
    end

    assign change = (q_next != q);
    assign qn     = ~q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q       <= RESET_VAL;
            changed <= 1'b0;
            sr_err  <= 1'b0;
            chg_cnt <= '0;
        end else begin
            q       <= q_next;
            changed <= change;
            // A new illegal combination wins over a simultaneous clear.
            if (sr_illegal) begin
                sr_err <= 1'b1;
            end else if (err_clr) begin
                sr_err <= 1'b0;
            end
            if (cnt_clr) begin
                chg_cnt <= '0;
            end else if (change && (chg_cnt != CNT_MAX)) begin
                chg_cnt <= chg_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_jk_ff_bank.sv
// Directed bench for jk_ff_bank (WIDTH=8, RESET_VAL=A5, CNT_W=3).
module tb_jk_ff_bank;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic [7:0] j;
    logic [7:0] k;
    logic       load;
    logic [7:0] load_data;
    logic       err_clr;
    logic       cnt_clr;
    logic [7:0] q;
    logic [7:0] qn;
    logic       changed;
    logic       sr_err;
    logic [2:0] chg_cnt;

    int checks = 0;
    int errors = 0;

    jk_ff_bank #(
        .WIDTH    (8),
        .RESET_VAL(8'hA5),
        .CNT_W    (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mode     (mode),
        .j        (j),
        .k        (k),
        .load     (load),
        .load_data(load_data),
        .err_clr  (err_clr),
        .cnt_clr  (cnt_clr),
        .q        (q),
        .qn       (qn),
        .changed  (changed),
        .sr_err   (sr_err),
        .chg_cnt  (chg_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b1; en = 1'b0; mode = 2'b00; j = 8'h00; k = 8'h00;
        load = 1'b0; load_data = 8'h00; err_clr = 1'b0; cnt_clr = 1'b0;

        // Reset asserted mid-cycle takes effect immediately
        #3 rst_n = 1'b0;
        #1;
        chk("rst_q", q, 8'hA5);
        chk("rst_qn", qn, 8'h5A);
        chk("rst_cnt", chg_cnt, 3'd0);
        chk("rst_changed", changed, 1'b0);
        chk("rst_sr_err", sr_err, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // JK truth table
        mode = 2'b00; en = 1'b1; j = 8'hF0; k = 8'h0F;
        step();
        chk("jk_setclr_q", q, 8'hF0);
        chk("jk_setclr_cnt", chg_cnt, 3'd1);
        j = 8'hFF; k = 8'hFF;
        step();
        chk("jk_toggle_q", q, 8'h0F);
        chk("jk_toggle_qn", qn, 8'hF0);
        chk("jk_toggle_changed", changed, 1'b1);
        chk("jk_toggle_cnt", chg_cnt, 3'd2);
        j = 8'h00; k = 8'h00;
        step();
        chk("jk_hold_q", q, 8'h0F);
        chk("jk_hold_changed", changed, 1'b0);

        // Mode sweep from 00
        load = 1'b1; load_data = 8'h00;
        step();
        chk("load00_q", q, 8'h00);
        load = 1'b0;
        mode = 2'b01; j = 8'h3C; k = 8'hFF;
        step();
        chk("d_q", q, 8'h3C);
        mode = 2'b10; j = 8'hFF; k = 8'h00;
        step();
        chk("t_q", q, 8'hC3);
        mode = 2'b11; j = 8'h01; k = 8'h80;
        step();
        chk("sr_q", q, 8'h43);
        chk("sr_changed", changed, 1'b1);
        chk("sr_no_err", sr_err, 1'b0);
        en = 1'b0; j = 8'hFF; k = 8'hFF;
        step();
        chk("hold_q", q, 8'h43);
        chk("hold_changed", changed, 1'b0);
        chk("hold_no_err", sr_err, 1'b0);

        // SR illegal combination and error clear
        load = 1'b1; load_data = 8'h00;
        step();
        load = 1'b0;
        en = 1'b1; mode = 2'b11; j = 8'h03; k = 8'h01;
        step();
        chk("sr_ill_q", q, 8'h02);
        chk("sr_ill_err", sr_err, 1'b1);
        en = 1'b0; j = 8'h00; k = 8'h00;
        step();
        step();
        chk("sr_err_sticky", sr_err, 1'b1);
        err_clr = 1'b1;
        step();
        chk("err_clr", sr_err, 1'b0);
        en = 1'b1; j = 8'h01; k = 8'h01;
        step();
        chk("err_clr_vs_set", sr_err, 1'b1);
        chk("err_clr_vs_set_q", q, 8'h02);
        en = 1'b0; j = 8'h00; k = 8'h00;
        step();
        chk("err_clr2", sr_err, 1'b0);
        err_clr = 1'b0;

        // Load priority: wins over mode/en, skips SR error check
        en = 1'b0; mode = 2'b11; j = 8'hFF; k = 8'hFF;
        load = 1'b1; load_data = 8'h5A; cnt_clr = 1'b1;
        step();
        chk("load_q", q, 8'h5A);
        chk("load_no_err", sr_err, 1'b0);
        chk("load_cnt_clr", chg_cnt, 3'd0);
        chk("load_changed", changed, 1'b1);
        cnt_clr = 1'b0; en = 1'b1;
        step();
        chk("reload_q", q, 8'h5A);
        chk("reload_changed", changed, 1'b0);
        chk("reload_cnt", chg_cnt, 3'd0);
        chk("reload_no_err", sr_err, 1'b0);
        load = 1'b0;

        // Counter saturation
        mode = 2'b10; en = 1'b1; j = 8'h01; k = 8'h00;
        for (int i = 1; i <= 10; i++) begin
            step();
            chk($sformatf("sat_cnt_%0d", i), chg_cnt, (i > 7) ? 32'd7 : 32'(i));
            chk($sformatf("sat_q_%0d", i), q, (i % 2 == 1) ? 8'h5B : 8'h5A);
        end
        cnt_clr = 1'b1;
        step();
        chk("cnt_clr_wins", chg_cnt, 3'd0);
        chk("cnt_clr_changed", changed, 1'b1);
        cnt_clr = 1'b0;
        step();
        chk("cnt_after_clr", chg_cnt, 3'd1);

        // Reset mid-operation, then first edge is not a change event
        #2 rst_n = 1'b0;
        #1;
        chk("rst2_q", q, 8'hA5);
        chk("rst2_cnt", chg_cnt, 3'd0);
        chk("rst2_changed", changed, 1'b0);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_q", q, 8'hA5);
        chk("post_rst_changed", changed, 1'b0);
        chk("post_rst_cnt", chg_cnt, 3'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jk_ff_bank.md
# jk_ff_bank

Parametrised bank of WIDTH independent edge-triggered flip-flop cells sharing one clock and one asynchronous active-low reset. It is the multi-bit successor to the single JK flip-flop. Each cell runs in a run-time selectable mode (JK, D, T, SR) and supports synchronous parallel load. The bank also provides change detection, a sticky SR-illegal error flag and a saturating change counter. It is used as a general-purpose control/status register primitive in the sequential library.

## Interface
- WIDTH, 8: number of flip-flop cells (≥1).
- RESET_VAL, {WIDTH{1'b0}}: value of q after reset.
- CNT_W, 8: width of chg_cnt (≥1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset; all state is cleared immediately on assertion; release is synchronous to clk.
- en  input  1  cell update enable; when 0, the mode logic holds q.
- mode  input  2  00=JK, 01=D, 10=T, 11=SR; applies to all cells.
- j  input  WIDTH  per-cell J / D / T / S input, depending on mode.
- k  input  WIDTH  per-cell K / R input; ignored in D and T modes.
- load  input  1  synchronous parallel load.
- load_data  input  WIDTH  value loaded when load=1.
- err_clr  input  1  clears sr_err.
- cnt_clr  input  1  clears chg_cnt.
- q  output  WIDTH  registered cell state.
- qn  output  WIDTH  always ~q, combinational from q.
- changed  output  1  registered; 1 for the cycle after any edge at which q changed.
- sr_err  output  1  sticky; set on an illegal SR combination.
- chg_cnt  output  CNT_W  saturating count of edges at which q changed.

## Operation
- Next-state priority per edge: load, then en, then hold.
  - load=1: q_next = load_data regardless of en and mode. No SR error check is made.
  - load=0, en=0: q_next = q.
  - load=0, en=1: each bit i follows mode:
    - JK: {j,k}=00 hold, 01 clear, 10 set, 11 toggle.
    - D: q_next[i] = j[i].
    - T: q_next[i] = q[i] ^ j[i].
    - SR: 00 hold, 01 clear, 10 set, 11 illegal. An illegal bit holds its value; the other bits still update.
- sr_err is set at an edge where load=0, en=1, mode=11 and any bit has j&k=1.
  - Once set, sr_err stays 1 until err_clr.
  - err_clr=1 clears sr_err at the edge. If a new illegal condition occurs at the same edge, set wins and sr_err stays 1.
- A change event is q_next != q at an edge.
  - changed is registered and equals the change event of the previous edge.
  - A load of a value equal to q is not a change event.
- chg_cnt increments by 1 per change event and saturates at 2^CNT_W−1 with no wrap.
  - cnt_clr=1 forces chg_cnt to 0 at that edge. Clear wins over a simultaneous increment.
- A mode change takes effect at the next edge. There is no internal mode state.

## Timing
- All outputs are registered except qn, which is ~q.
- Latency is 1 cycle: inputs sampled at edge N are visible on q at edge N.
- changed and chg_cnt update at the same edge as q and reflect that edge's transition.
- Reset values, applied asynchronously while rst_n=0:
  - q=RESET_VAL, qn=~RESET_VAL.
  - changed=0, sr_err=0, chg_cnt=0.
- Reset asserted mid-operation discards any pending update. The first edge after rst_n rises applies normal next-state logic. Reset itself is not counted as a change event.
- Inputs must be stable around the rising edge of clk. There are no combinational paths from inputs to outputs.

## Test plan
- Reset and JK truth table (WIDTH=8, RESET_VAL=8'hA5):
  - Assert rst_n low mid-cycle: q=A5 immediately, qn=5A, chg_cnt=0.
  - Release reset; mode=00, en=1, j=F0, k=0F: next edge gives q=F0.
  - j=FF, k=FF: q=0F, changed=1, chg_cnt=2.
- Mode sweep from q=00:
  - D with j=3C: q=3C.
  - T with j=FF: q=C3.
  - SR with j=01, k=80: q=43.
  - Hold: en=0 with any j/k leaves q=43 and changed=0 on the following cycle.
- SR illegal and error clear:
  - mode=11, q=00, j=03, k=01: bit0 holds, bit1 sets, q=02, sr_err=1.
  - sr_err stays 1 through idle cycles.
  - err_clr alone clears it.
  - err_clr together with a new illegal combination leaves sr_err=1.
- Load priority:
  - en=0, load=1, load_data=5A, mode=11, j=k=FF: q=5A, sr_err unchanged.
  - Loading 5A again: changed=0, chg_cnt not incremented.
- Counter saturation and clear (CNT_W=3):
  - T mode with j=01 for 10 cycles: chg_cnt runs 1..7, then holds at 7.
  - cnt_clr together with a toggle: chg_cnt=0 at that edge, 1 at the next toggle.
